hazard_ctrl_d: RTL
==================

# hazard_ctrl_d

Decode-stage hazard controller: the producer side of the decode operand-forwarding interface. It tracks the destination registers of in-flight instructions in a shadow pipeline (E, M, W) and, for the instruction currently in D, drives three signals: the branch-comparator forward selects, the JALR base-register forward select, and the pipeline stall/bubble controls. It sits beside the decode stage and feeds the decode forwarding mux, the F/D pipeline-register enables and the D/E register clear.

## Interface
Parameters:
- REG_AW, 5, register-index width.
- MAX_STALL, 2, maximum legal consecutive stall cycles before `oHazardErr` is raised.

Ports:
- iClk  in  1  clock, rising edge.
- iRstN  in  1  reset, asynchronous, active-low.
- iValidD  in  1  D holds a real instruction (0 = bubble).
- iRs1D, iRs2D  in  REG_AW  source register indices in D.
- iUsesRs1D, iUsesRs2D  in  1  the D instruction reads rs1/rs2.
- iBranchD  in  1  conditional branch; its comparison is performed in D.
- iJalrD  in  1  JALR; its base register is consumed in D.
- iRdD  in  REG_AW  destination register index in D.
- iRegWriteD  in  1  the D instruction writes rd.
- iLoadD  in  1  the D instruction is a load (result available only in W).
- iStallExt  in  1  global freeze (memory wait). All pipeline registers, including the shadow pipeline, hold.
- oCompOp1Select, oCompOp2Select  out  1  select the M-stage ALU result for comparator operand 1/2.
- oForwardRegOffset  out  1  select the M-stage ALU result for the JALR base.
- oStallF, oStallD  out  1  hold the PC and the F/D register.
- oFlushE  out  1  load a bubble into D/E.
- oStallCnt  out  2  consecutive hazard-stall cycles, saturating at 3.
- oHazardErr  out  1  sticky; set when oStallCnt exceeds MAX_STALL.

## Operation
- **Shadow entries.** Entries E, M and W each hold {valid, rd, regwrite, load}.
- **Match.** Define match(X, rs) = X.valid & X.regwrite & (X.rd == rs) & (rs != 0).
- **Early consumers.** rsEarly1 = iValidD & iUsesRs1D & (iBranchD | iJalrD). rsEarly2 = iValidD & iUsesRs2D & iBranchD.
- **Late consumers.** rsLate1 = iValidD & iUsesRs1D, excluding early use. rsLate2 is formed the same way for rs2.
- **Hazard stall.** hz is the OR of the following terms, evaluated for each operand n:
  - rsEarly_n & match(E, rs_n): the ALU result is not ready yet.
  - rsEarly_n & match(M, rs_n) & M.load: load data exists only in W.
  - rsLate_n & match(E, rs_n) & E.load: classic load-use.
- **Stall outputs.** oStallF = oStallD = oFlushE = hz.
- **Forward selects.**
  - oCompOp1Select = ~hz & iBranchD & rsEarly1 & match(M, rs1) & ~M.load.
  - oCompOp2Select is the same expression for rs2.
  - oForwardRegOffset = ~hz & iJalrD & rsEarly1 & match(M, rs1) & ~M.load.
- **Priority.** An E match takes priority over an M match. A W match produces no action, because the register file is write-through (written in the first half-cycle).
- **Shadow advance** on a rising edge when iStallExt = 0:
  - W <= M and M <= E.
  - E <= {iValidD & ~hz, iRdD, iRegWriteD, iLoadD}. A stall inserts a bubble into E.
- **Freeze.** When iStallExt = 1, all shadow entries, oStallCnt and oHazardErr hold.
- **Stall counter.** Two states:
  - RUN: oStallCnt = 0. Go to STALL when hz = 1.
  - STALL: oStallCnt increments and saturates at 3. Return to RUN, with the count cleared, when hz = 0.
- **Error flag.** oHazardErr sets when oStallCnt > MAX_STALL and is cleared only by reset.
- **Reset.** All shadow valid bits = 0; rd, regwrite and load = 0; oStallCnt = 0; oHazardErr = 0. Consequently all combinational outputs are 0 out of reset.

## Timing
- hz and all forward and stall outputs are combinational from the D inputs and the registered shadow state: zero-cycle latency.
- Shadow entries, oStallCnt and oHazardErr update on the rising edge only.
- Stall duration, all re-evaluated each cycle with no extra logic:
  - Branch dependent on an ALU op in E: 1 stall cycle, then a forward from M.
  - Branch dependent on a load in E: 2 stall cycles. The release then uses W via the register file.
  - Late consumer dependent on a load in E: 1 stall cycle.
- iStallExt together with hz: outputs still reflect hz, but nothing advances.
- Reset asserted mid-stall clears all state asynchronously. The next evaluation sees an empty shadow pipeline, so hz = 0.

## Test plan
- **ALU to branch, one stall then forward.** Issue `add x5` (rd = 5, regwrite) followed by `beq x5, x0`.
  - Cycle 1: hz = 1, oStallCnt = 0.
  - Cycle 2: oCompOp1Select = 1, hz = 0, oStallCnt = 1.
  - Cycle 3: oStallCnt returns to 0.
- **Load to branch, two stalls.** Issue `lw x6` followed by `bne x0, x6`. Expect hz = 1 for 2 cycles, then oCompOp2Select = 0 and hz = 0. oStallCnt reads 2 at release and oHazardErr stays 0.
- **Load to JALR and load-use.**
  - `lw x7`, then `jalr x7`: 2 stalls, and oForwardRegOffset is never 1.
  - `lw x7`, then `add x8, x7`: exactly 1 stall.
- **x0 and no-write cases.** Either of the following must give hz = 0 and all selects = 0:
  - rd = 0 with regwrite = 1, followed by `beq x0, x0`;
  - a store (regwrite = 0) with rd field = 5, followed by `beq x5`.
- **Freeze.** Start the `lw x6` → `bne x6` sequence. Raise iStallExt for 3 cycles during the first stall cycle. hz remains 1 and the shadow pipeline holds. After release, exactly one more stall follows.
- **Reset mid-stall.** Pull iRstN low during a hazard stall. All outputs go to 0 immediately, oStallCnt = 0 and oHazardErr = 0.

Source files
------------

// File: rtl/hazard_ctrl_d.sv
// Decode-stage hazard controller: tracks in-flight destinations in a shadow E/M/W
// pipeline and drives comparator/JALR forward selects plus stall/bubble controls for D.
module hazard_ctrl_d #(
    parameter int REG_AW    = 5,
    parameter int MAX_STALL = 2
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValidD,
    input  logic [REG_AW-1:0] iRs1D,
    input  logic [REG_AW-1:0] iRs2D,
    input  logic              iUsesRs1D,
    input  logic              iUsesRs2D,
    input  logic              iBranchD,
    input  logic              iJalrD,
    input  logic [REG_AW-1:0] iRdD,
    input  logic              iRegWriteD,
    input  logic              iLoadD,
    input  logic              iStallExt,
    output logic              oCompOp1Select,
    output logic              oCompOp2Select,
    output logic              oForwardRegOffset,
    output logic              oStallF,
    output logic              oStallD,
    output logic              oFlushE,
    output logic [1:0]        oStallCnt,
    output logic              oHazardErr,
    output logic              dbg_fsm,
    output logic [REG_AW+2:0] dbg_w
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    logic              e_valid, m_valid, w_valid;
    logic [REG_AW-1:0] e_rd, m_rd, w_rd;
    logic              e_rw, m_rw, w_rw;
    logic              e_ld, m_ld, w_ld;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic hz;
    logic early1, early2, late1, late2;
    logic e_m1, e_m2, m_m1, m_m2;

    function automatic logic match(input logic v, input logic rw,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
        return v & rw & (rd == rs) & (rs != '0);
    endfunction

    always_comb begin
        early1 = iValidD & iUsesRs1D & (iBranchD | iJalrD);
        early2 = iValidD & iUsesRs2D & iBranchD;
        late1  = iValidD & iUsesRs1D & ~early1;
        late2  = iValidD & iUsesRs2D & ~early2;
        e_m1   = match(e_valid, e_rw, e_rd, iRs1D);
        e_m2   = match(e_valid, e_rw, e_rd, iRs2D);
        m_m1   = match(m_valid, m_rw, m_rd, iRs1D);
        m_m2   = match(m_valid, m_rw, m_rd, iRs2D);
        // W matches need nothing: the register file writes in the first half-cycle.
        hz = (early1 & e_m1) | (early1 & m_m1 & m_ld) | (late1 & e_m1 & e_ld)
           | (early2 & e_m2) | (early2 & m_m2 & m_ld) | (late2 & e_m2 & e_ld);
    end

    always_comb begin
        oStallF           = hz;
        oStallD           = hz;
        oFlushE           = hz;
        oCompOp1Select    = ~hz & iBranchD & early1 & m_m1 & ~m_ld;
        oCompOp2Select    = ~hz & iBranchD & early2 & m_m2 & ~m_ld;
        oForwardRegOffset = ~hz & iJalrD & early1 & m_m1 & ~m_ld;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            e_valid <= 1'b0; e_rd <= '0; e_rw <= 1'b0; e_ld <= 1'b0;
            m_valid <= 1'b0; m_rd <= '0; m_rw <= 1'b0; m_ld <= 1'b0;
            w_valid <= 1'b0; w_rd <= '0; w_rw <= 1'b0; w_ld <= 1'b0;
        end else if (!iStallExt) begin
            w_valid <= m_valid; w_rd <= m_rd; w_rw <= m_rw; w_ld <= m_ld;
            m_valid <= e_valid; m_rd <= e_rd; m_rw <= e_rw; m_ld <= e_ld;
            // A stalled D instruction enters E as a bubble.
            e_valid <= iValidD & ~hz;
            e_rd    <= iRdD;
            e_rw    <= iRegWriteD;
            e_ld    <= iLoadD;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else if (!iStallExt) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (hz) begin
                    state_d = STALL;
                    cnt_d   = 2'd1;
                end
            end
            STALL: begin
                if (hz) begin
                    cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                end else begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
        err_d = err_q | (int'(cnt_d) > MAX_STALL);
    end

    always_comb begin
        oStallCnt  = cnt_q;
        oHazardErr = err_q;
        dbg_fsm    = state_q;
        dbg_w      = {w_valid, w_rd, w_rw, w_ld};
    end

endmodule
